// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types, command codes and key decode for the keypad front end.
// Key index is {row, col}, i.e. 4*row + col.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN,
        DEB_PRESS,
        EMIT,
        WAIT_REL
    } state_t;

    localparam logic [1:0] CMD_IDLE   = 2'b00;
    localparam logic [1:0] CMD_ARM    = 2'b01;
    localparam logic [1:0] CMD_DISARM = 2'b10;
    localparam logic [1:0] CMD_CANCEL = 2'b11;

    typedef struct packed {
        logic       is_digit;
        logic       is_cmd;
        logic [3:0] value;
    } key_t;

    function automatic logic [3:0] col_mask(input logic [1:0] c);
        return ~(4'b0001 << c);
    endfunction

    // '*', '#' and 'D' decode to neither digit nor command and are dropped
    function automatic key_t key_decode(input logic [3:0] k);
        key_t d;
        d = '0;
        case (k)
            4'd0:    d = '{1'b1, 1'b0, 4'd1};
            4'd1:    d = '{1'b1, 1'b0, 4'd2};
            4'd2:    d = '{1'b1, 1'b0, 4'd3};
            4'd3:    d = '{1'b0, 1'b1, {2'b00, CMD_ARM}};
            4'd4:    d = '{1'b1, 1'b0, 4'd4};
            4'd5:    d = '{1'b1, 1'b0, 4'd5};
            4'd6:    d = '{1'b1, 1'b0, 4'd6};
            4'd7:    d = '{1'b0, 1'b1, {2'b00, CMD_DISARM}};
            4'd8:    d = '{1'b1, 1'b0, 4'd7};
            4'd9:    d = '{1'b1, 1'b0, 4'd8};
            4'd10:   d = '{1'b1, 1'b0, 4'd9};
            4'd11:   d = '{1'b0, 1'b1, {2'b00, CMD_CANCEL}};
            4'd13:   d = '{1'b1, 1'b0, 4'd0};
            default: d = '0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/keypad_if.sv
// keypad_if: keypad matrix lines plus the decoded key stimulus.
// master = keypad front end, slave = keypad/consumer side.
interface keypad_if;
    logic [3:0] row_sense;
    logic [3:0] col_drive;
    logic [3:0] digit;
    logic       input_digit;
    logic [1:0] command;

    modport master (
        input  row_sense,
        output col_drive,
        output digit,
        output input_digit,
        output command
    );

    modport slave (
        output row_sense,
        input  col_drive,
        input  digit,
        input  input_digit,
        input  command
    );
endinterface

// File: rtl/keypad_sync2.sv
// keypad_sync2: 4-bit two-flop synchroniser for the row inputs.
// Resets to all ones (no key down).
module keypad_sync2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] d,
    output logic [3:0] q
);
    logic [3:0] meta;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= 4'hF;
            q    <= 4'hF;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/keypad_frontend.sv
// keypad_frontend: 4x4 keypad scan, debounce and decode into one-cycle pulses.
// Define KEYPAD_MULTIKEY_REJECT_EN to reject frames with more than one key down.
module keypad_frontend
    import keypad_pkg::*;
#(
    parameter int SCAN_CYCLES     = 4,
    parameter int DEBOUNCE_CYCLES = 8
) (
    input  logic     clk,
    input  logic     reset,
    keypad_if.master kp
);
    localparam int SW = $clog2(SCAN_CYCLES);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_CYCLES - 1);
    localparam logic [SW-1:0] SETTLE    = SW'(2);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);

    state_t        state, state_n;
    logic [1:0]    col_idx, col_idx_n;
    logic [1:0]    cand_row, cand_row_n;
    logic [1:0]    cand_col, cand_col_n;
    logic          hit, hit_n;
    logic          multi, multi_n;
    logic [SW-1:0] scan_cnt, scan_cnt_n;
    logic [DW-1:0] deb_cnt, deb_cnt_n;
    logic [3:0]    col_drive_n, digit_n;
    logic          input_digit_n;
    logic [1:0]    command_n;

    logic [3:0] rs, low;
    logic [1:0] col_row;
    logic       col_any, col_multi, frame_multi, reject;
    key_t       dec;

    keypad_sync2 u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (kp.row_sense),
        .q     (rs)
    );

    always_comb begin
        low       = ~rs;
        col_any   = |low;
        col_multi = |(low & (low - 4'd1));
        col_row   = 2'd0;
        if (low[0])      col_row = 2'd0;
        else if (low[1]) col_row = 2'd1;
        else if (low[2]) col_row = 2'd2;
        else if (low[3]) col_row = 2'd3;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= SCAN;
        else       state <= state_n;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col_idx        <= 2'd0;
            cand_row       <= 2'd0;
            cand_col       <= 2'd0;
            hit            <= 1'b0;
            multi          <= 1'b0;
            scan_cnt       <= '0;
            deb_cnt        <= '0;
            kp.col_drive   <= 4'b1110;
            kp.digit       <= 4'd0;
            kp.input_digit <= 1'b0;
            kp.command     <= CMD_IDLE;
        end else begin
            col_idx        <= col_idx_n;
            cand_row       <= cand_row_n;
            cand_col       <= cand_col_n;
            hit            <= hit_n;
            multi          <= multi_n;
            scan_cnt       <= scan_cnt_n;
            deb_cnt        <= deb_cnt_n;
            kp.col_drive   <= col_drive_n;
            kp.digit       <= digit_n;
            kp.input_digit <= input_digit_n;
            kp.command     <= command_n;
        end
    end

    always_comb begin
        state_n       = state;
        col_idx_n     = col_idx;
        cand_row_n    = cand_row;
        cand_col_n    = cand_col;
        hit_n         = hit;
        multi_n       = multi;
        scan_cnt_n    = scan_cnt;
        deb_cnt_n     = deb_cnt;
        col_drive_n   = kp.col_drive;
        digit_n       = 4'd0;
        input_digit_n = 1'b0;
        command_n     = CMD_IDLE;
        frame_multi   = multi | col_multi | (hit & col_any);
`ifdef KEYPAD_MULTIKEY_REJECT_EN
        reject        = frame_multi;
`else
        reject        = 1'b0;
`endif
        dec           = key_decode({cand_row, cand_col});

        unique case (state)
            SCAN: begin
                if (scan_cnt == SCAN_LAST) begin
                    scan_cnt_n = '0;
                    if (!hit && col_any) begin
                        cand_row_n = col_row;
                        cand_col_n = col_idx;
                    end
                    hit_n       = hit | col_any;
                    multi_n     = frame_multi;
                    col_idx_n   = col_idx + 2'd1;
                    col_drive_n = col_mask(col_idx + 2'd1);
                    if (col_idx == 2'd3) begin
                        hit_n   = 1'b0;
                        multi_n = 1'b0;
                        if ((hit | col_any) && !reject) begin
                            state_n     = DEB_PRESS;
                            col_idx_n   = 2'd0;
                            col_drive_n = col_mask(cand_col_n);
                        end
                    end
                end else begin
                    scan_cnt_n = scan_cnt + 1'b1;
                end
            end
            DEB_PRESS: begin
                // first two cycles still show the old column through the synchroniser
                if (scan_cnt != SETTLE) begin
                    scan_cnt_n = scan_cnt + 1'b1;
                end else if (rs[cand_row]) begin
                    state_n     = SCAN;
                    scan_cnt_n  = '0;
                    deb_cnt_n   = '0;
                    col_idx_n   = 2'd0;
                    col_drive_n = 4'b1110;
                end else if (deb_cnt == DEB_LAST) begin
                    state_n    = EMIT;
                    scan_cnt_n = '0;
                    deb_cnt_n  = '0;
                    if (dec.is_digit) begin
                        digit_n       = dec.value;
                        input_digit_n = 1'b1;
                    end else if (dec.is_cmd) begin
                        command_n = dec.value[1:0];
                    end
                end else begin
                    deb_cnt_n = deb_cnt + 1'b1;
                end
            end
            EMIT: begin
                state_n   = WAIT_REL;
                deb_cnt_n = '0;
            end
            WAIT_REL: begin
                if (!rs[cand_row]) begin
                    deb_cnt_n = '0;
                end else if (deb_cnt == DEB_LAST) begin
                    state_n     = SCAN;
                    deb_cnt_n   = '0;
                    scan_cnt_n  = '0;
                    col_idx_n   = 2'd0;
                    col_drive_n = 4'b1110;
                end else begin
                    deb_cnt_n = deb_cnt + 1'b1;
                end
            end
            default: state_n = SCAN;
        endcase
    end
endmodule

// File: tb/tb_keypad_frontend.sv
// tb_keypad_frontend: directed vector table plus hand sequences for bounce and reset.
// Expectations for multi-key frames follow KEYPAD_MULTIKEY_REJECT_EN.
module tb_keypad_frontend;
    localparam int SC = 4;
    localparam int DB = 8;

    typedef struct {
        logic [15:0] keys;
        bit          pulse;
        bit          is_dig;
        logic [3:0]  val;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] pressed = 16'h0;
    logic [3:0]  rows;

    int n_checks = 0;
    int n_fail = 0;
    int n_pulse = 0;
    int cyc = 0;
    int pulse_cyc = 0;
    int excl_err = 0;
    logic       p_dig = 1'b0;
    logic [3:0] p_val = 4'd0;

    keypad_if kp();

    keypad_frontend #(
        .SCAN_CYCLES     (SC),
        .DEBOUNCE_CYCLES (DB)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .kp    (kp)
    );

    always #5 clk = ~clk;

    // matrix model: a pressed key pulls its row low while its column is driven
    always_comb begin
        rows = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[4*r+c] && !kp.col_drive[c]) rows[r] = 1'b0;
    end
    assign kp.row_sense = rows;

    always @(negedge clk) begin
        cyc++;
        if (kp.input_digit || kp.command != 2'b00) begin
            n_pulse++;
            pulse_cyc = cyc;
            p_dig = kp.input_digit;
            p_val = kp.input_digit ? kp.digit : {2'b00, kp.command};
        end
        if (kp.input_digit && kp.command != 2'b00) excl_err++;
        if (!kp.input_digit && kp.digit != 4'd0) excl_err++;
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        @(posedge clk);
        n_pulse = 0;
        pressed = v.keys;
        repeat (60) @(posedge clk);
        pressed = 16'h0;
        repeat (40) @(posedge clk);
        @(negedge clk);
        check($sformatf("vec%0d pulse count", idx), n_pulse, v.pulse ? 1 : 0);
        if (v.pulse)
            check($sformatf("vec%0d value", idx), int'({p_dig, p_val}), int'({v.is_dig, v.val}));
    endtask

    vec_t vt[$];

    initial begin
        logic [3:0] e;
        logic [3:0] seen;
        int stable_start;

        vt.push_back('{16'h0001, 1'b1, 1'b1, 4'd1});
        vt.push_back('{16'h0008, 1'b1, 1'b0, 4'd1});
        vt.push_back('{16'h0001, 1'b1, 1'b1, 4'd1});
        vt.push_back('{16'h0002, 1'b1, 1'b1, 4'd2});
        vt.push_back('{16'h0010, 1'b1, 1'b1, 4'd4});
        vt.push_back('{16'h0080, 1'b1, 1'b0, 4'd2});
        vt.push_back('{16'h0800, 1'b1, 1'b0, 4'd3});
        vt.push_back('{16'h2000, 1'b1, 1'b1, 4'd0});
        vt.push_back('{16'h0400, 1'b1, 1'b1, 4'd9});
        vt.push_back('{16'h0100, 1'b1, 1'b1, 4'd7});
        vt.push_back('{16'h4000, 1'b0, 1'b0, 4'd0});
        vt.push_back('{16'h1000, 1'b0, 1'b0, 4'd0});
        vt.push_back('{16'h8000, 1'b0, 1'b0, 4'd0});
`ifdef KEYPAD_MULTIKEY_REJECT_EN
        vt.push_back('{16'h2001, 1'b0, 1'b0, 4'd0});
        vt.push_back('{16'h0011, 1'b0, 1'b0, 4'd0});
        vt.push_back('{16'h0044, 1'b0, 1'b0, 4'd0});
        vt.push_back('{16'h0012, 1'b0, 1'b0, 4'd0});
`else
        vt.push_back('{16'h2001, 1'b1, 1'b1, 4'd1});
        vt.push_back('{16'h0011, 1'b1, 1'b1, 4'd1});
        vt.push_back('{16'h0044, 1'b1, 1'b1, 4'd3});
        vt.push_back('{16'h0012, 1'b1, 1'b1, 4'd4});
`endif

        // reset state
        repeat (3) @(negedge clk);
        check("reset col_drive", int'(kp.col_drive), 14);
        check("reset digit", int'(kp.digit), 0);
        check("reset input_digit", int'(kp.input_digit), 0);
        check("reset command", int'(kp.command), 0);

        // idle column rotation
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            e = ~(4'b0001 << (i % 4));
            check($sformatf("idle col_drive step%0d", i), int'(kp.col_drive), int'(e));
            repeat (SC) @(posedge clk);
            @(negedge clk);
        end
        check("idle no pulse", n_pulse, 0);

        foreach (vt[i]) run_vec(vt[i], i);

        seen = 4'h0;
        repeat (4 * SC) begin
            @(negedge clk);
            seen = seen | ~kp.col_drive;
        end
        check("scan resumed all columns", int'(seen), 15);

        // bouncing '5' then a clean hold
        @(posedge clk);
        n_pulse = 0;
        for (int i = 0; i < 10; i++) begin
            pressed = (i % 2 == 0) ? 16'h0020 : 16'h0000;
            repeat (3) @(posedge clk);
        end
        pressed = 16'h0020;
        stable_start = cyc;
        repeat (60) @(posedge clk);
        pressed = 16'h0;
        repeat (40) @(posedge clk);
        @(negedge clk);
        check("bounce pulse count", n_pulse, 1);
        check("bounce value", int'({p_dig, p_val}), int'({1'b1, 4'd5}));
        check("bounce stable wait", int'((pulse_cyc - stable_start) >= DB), 1);

        // reset two clocks into press debounce of 'B'
        @(negedge clk);
        reset = 1'b1;
        pressed = 16'h0080;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        n_pulse = 0;
        repeat (4 * SC + 2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        check("no pulse before reset", n_pulse, 0);
        repeat (3) @(negedge clk);
        check("outputs cleared in reset", int'({kp.input_digit, kp.command}), 0);
        reset = 1'b0;
        repeat (60) @(posedge clk);
        pressed = 16'h0;
        repeat (40) @(posedge clk);
        @(negedge clk);
        check("post-reset B pulse count", n_pulse, 1);
        check("post-reset B value", int'({p_dig, p_val}), int'({1'b0, 4'd2}));

        check("digit/command exclusivity", excl_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
